// File: rtl/chunked_argmax_accumulator.sv
// Reduces NUM_CHUNKS consecutive (max, argmax) chunk results into one frame-level
// signed maximum and global index; on equal values the later chunk wins.
module chunked_argmax_accumulator #(
  parameter  int WIDTH      = 5,
  parameter  int ARG_WIDTH  = 4,
  parameter  int NUM_CHUNKS = 4,
  localparam int CHUNK_BITS = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_max,
  input  logic [ARG_WIDTH-1:0]            in_argmax,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_max,
  output logic [CHUNK_BITS+ARG_WIDTH-1:0] out_argmax,
  output logic [CHUNK_BITS-1:0]           chunk_count
);

  localparam int IDX_W = CHUNK_BITS + ARG_WIDTH;
  localparam logic [CHUNK_BITS-1:0] LAST_CHUNK = CHUNK_BITS'(NUM_CHUNKS - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [CHUNK_BITS-1:0] count_r, count_s;
  logic [WIDTH-1:0]      best_max_r, best_max_s;
  logic [IDX_W-1:0]      best_idx_r, best_idx_s;
  logic [WIDTH-1:0]      out_max_r, out_max_s;
  logic [IDX_W-1:0]      out_argmax_r, out_argmax_s;

  assign in_ready    = (state_r == ACCUM);
  assign out_valid   = (state_r == DONE);
  assign out_max     = out_max_r;
  assign out_argmax  = out_argmax_r;
  assign chunk_count = count_r;

  // Next-state, running-best and frame-result update logic
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    best_max_s   = best_max_r;
    best_idx_s   = best_idx_r;
    out_max_s    = out_max_r;
    out_argmax_s = out_argmax_r;
    if (clear) begin
      // Abort drops the partial frame and any pending result; outputs hold.
      state_s = ACCUM;
      count_s = '0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (in_valid) begin
            // First chunk always loads; ">=" lets later chunks win ties.
            if ((count_r == '0) || ($signed(in_max) >= $signed(best_max_r))) begin
              best_max_s = in_max;
              best_idx_s = {count_r, in_argmax};
            end else begin
              best_max_s = best_max_r;
              best_idx_s = best_idx_r;
            end
            if (count_r == LAST_CHUNK) begin
              state_s      = DONE;
              count_s      = '0;
              out_max_s    = best_max_s;
              out_argmax_s = best_idx_s;
            end else begin
              count_s = count_r + CHUNK_BITS'(1);
            end
          end else begin
            state_s = ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_s = ACCUM;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = ACCUM;
          count_s = '0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ACCUM;
      count_r      <= '0;
      best_max_r   <= '0;
      best_idx_r   <= '0;
      out_max_r    <= '0;
      out_argmax_r <= '0;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      best_max_r   <= best_max_s;
      best_idx_r   <= best_idx_s;
      out_max_r    <= out_max_s;
      out_argmax_r <= out_argmax_s;
    end
  end

endmodule
